// File: rtl/pong_if.sv
// Pong engine bundle: per-frame controls in, LED-renderer positions and scores out.
interface pong_if;
   logic       tick;
   logic       p1_up;
   logic       p1_dn;
   logic       p2_up;
   logic       p2_dn;
   logic       serve;
   logic [5:0] bx;
   logic [5:0] by;
   logic [5:0] p1y;
   logic [5:0] p2y;
   logic [2:0] sc1;
   logic [2:0] sc2;
   logic       game_over;
   logic       winner;

   modport master (
      output tick, p1_up, p1_dn, p2_up, p2_dn, serve,
      input  bx, by, p1y, p2y, sc1, sc2, game_over, winner
   );

   modport slave (
      input  tick, p1_up, p1_dn, p2_up, p2_dn, serve,
      output bx, by, p1y, p2y, sc1, sc2, game_over, winner
   );
endinterface

// File: rtl/pong_engine.sv
// Pong game engine on a 64x64 field: ball, two paddles, scoring and game flow.
// Optional macro PONG_AI_EN: P2 paddle tracks the ball instead of p2_up/p2_dn.
module pong_engine #(
   parameter int PADDLE_LEN  = 8,
   parameter int WIN_SCORE   = 7,
   parameter int PAUSE_TICKS = 32
) (
   input  logic  clk,
   input  logic  rst,
   pong_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

   localparam logic [5:0] PAD_MAX  = 6'(64 - PADDLE_LEN);
   localparam logic [5:0] PAD_MID  = 6'((64 - PADDLE_LEN) / 2);
   localparam logic [5:0] CENTRE   = 6'd32;
   localparam logic [6:0] PAD_LEN7 = 7'(PADDLE_LEN);
   localparam logic [2:0] WIN3     = 3'(WIN_SCORE);
   localparam logic [7:0] PAUSE8   = 8'(PAUSE_TICKS);

   state_t     state_reg, state_next;
   logic [5:0] bx_reg, bx_next, by_reg, by_next;
   logic [5:0] p1y_reg, p1y_next, p2y_reg, p2y_next;
   logic [2:0] sc1_reg, sc1_next, sc2_reg, sc2_next;
   logic       go_reg, go_next, win_reg, win_next;
   logic       dx_reg, dx_next;   // 1 = moving right
   logic       dy_reg, dy_next;   // 1 = moving down
   logic [7:0] pause_reg, pause_next;
   logic       p2_up_eff, p2_dn_eff;

   // One paddle step: exclusive up/down moves a row, clamped to the field.
   function automatic logic [5:0] paddle_step(input logic [5:0] y, input logic up, input logic dn);
      logic [5:0] r;
      r = y;
      if (up && !dn && y != 6'd0)
         r = y - 6'd1;
      else if (dn && !up && y < PAD_MAX)
         r = y + 6'd1;
      return r;
   endfunction

   // True when row y lies on the paddle whose top row is top.
   function automatic logic in_span(input logic [5:0] y, input logic [5:0] top);
      return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} < ({1'b0, top} + PAD_LEN7));
   endfunction

`ifdef PONG_AI_EN
   logic [6:0] p2_mid;
   assign p2_mid    = {1'b0, p2y_reg} + 7'(PADDLE_LEN / 2);
   assign p2_up_eff = p2_mid > {1'b0, by_reg};
   assign p2_dn_eff = p2_mid < {1'b0, by_reg};
`else
   assign p2_up_eff = bus.p2_up;
   assign p2_dn_eff = bus.p2_dn;
`endif

   // Next-state, ball physics, scoring and paddle motion.
   always_comb begin
      state_next = state_reg;
      bx_next    = bx_reg;
      by_next    = by_reg;
      p1y_next   = p1y_reg;
      p2y_next   = p2y_reg;
      sc1_next   = sc1_reg;
      sc2_next   = sc2_reg;
      go_next    = go_reg;
      win_next   = win_reg;
      dx_next    = dx_reg;
      dy_next    = dy_reg;
      pause_next = pause_reg;

      if (bus.tick && state_reg != OVER) begin
         p1y_next = paddle_step(p1y_reg, bus.p1_up, bus.p1_dn);
         p2y_next = paddle_step(p2y_reg, p2_up_eff, p2_dn_eff);
      end

      case (state_reg)
         IDLE: begin
            bx_next = CENTRE;
            by_next = CENTRE;
            if (bus.serve)
               state_next = PLAY;
         end
         PLAY: begin
            if (bus.tick) begin
               if (!dx_reg && bx_reg == 6'd0) begin
                  // P1 missed; ball stays frozen where it left the field.
                  if (sc2_reg != WIN3)
                     sc2_next = sc2_reg + 3'd1;
                  if (sc2_reg + 3'd1 >= WIN3) begin
                     state_next = OVER;
                     go_next    = 1'b1;
                     win_next   = 1'b1;
                  end else begin
                     state_next = POINT;
                     pause_next = PAUSE8;
                  end
               end else if (dx_reg && bx_reg == 6'd63) begin
                  if (sc1_reg != WIN3)
                     sc1_next = sc1_reg + 3'd1;
                  if (sc1_reg + 3'd1 >= WIN3) begin
                     state_next = OVER;
                     go_next    = 1'b1;
                     win_next   = 1'b0;
                  end else begin
                     state_next = POINT;
                     pause_next = PAUSE8;
                  end
               end else begin
                  // Vertical and horizontal reflections are independent so corners reflect both.
                  if (!dy_reg && by_reg == 6'd0) begin
                     dy_next = 1'b1;
                     by_next = 6'd1;
                  end else if (dy_reg && by_reg == 6'd63) begin
                     dy_next = 1'b0;
                     by_next = 6'd62;
                  end else begin
                     by_next = dy_reg ? by_reg + 6'd1 : by_reg - 6'd1;
                  end
                  // Paddle hits use the paddle rows as they stood before this tick.
                  if (!dx_reg && bx_reg == 6'd2 && in_span(by_reg, p1y_reg)) begin
                     dx_next = 1'b1;
                     bx_next = 6'd3;
                  end else if (dx_reg && bx_reg == 6'd61 && in_span(by_reg, p2y_reg)) begin
                     dx_next = 1'b0;
                     bx_next = 6'd60;
                  end else begin
                     bx_next = dx_reg ? bx_reg + 6'd1 : bx_reg - 6'd1;
                  end
               end
            end
         end
         POINT: begin
            if (bus.tick) begin
               if (pause_reg <= 8'd1) begin
                  // dx already points at the conceding side, so only dy flips.
                  bx_next    = CENTRE;
                  by_next    = CENTRE;
                  dy_next    = ~dy_reg;
                  pause_next = 8'd0;
                  state_next = IDLE;
               end else begin
                  pause_next = pause_reg - 8'd1;
               end
            end
         end
         OVER: begin
            if (bus.serve) begin
               sc1_next   = 3'd0;
               sc2_next   = 3'd0;
               go_next    = 1'b0;
               win_next   = 1'b0;
               bx_next    = CENTRE;
               by_next    = CENTRE;
               p1y_next   = PAD_MID;
               p2y_next   = PAD_MID;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with synchronous reset overriding every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         bx_reg    <= CENTRE;
         by_reg    <= CENTRE;
         p1y_reg   <= PAD_MID;
         p2y_reg   <= PAD_MID;
         sc1_reg   <= 3'd0;
         sc2_reg   <= 3'd0;
         go_reg    <= 1'b0;
         win_reg   <= 1'b0;
         dx_reg    <= 1'b1;
         dy_reg    <= 1'b1;
         pause_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         bx_reg    <= bx_next;
         by_reg    <= by_next;
         p1y_reg   <= p1y_next;
         p2y_reg   <= p2y_next;
         sc1_reg   <= sc1_next;
         sc2_reg   <= sc2_next;
         go_reg    <= go_next;
         win_reg   <= win_next;
         dx_reg    <= dx_next;
         dy_reg    <= dy_next;
         pause_reg <= pause_next;
      end
   end

   assign bus.bx        = bx_reg;
   assign bus.by        = by_reg;
   assign bus.p1y       = p1y_reg;
   assign bus.p2y       = p2y_reg;
   assign bus.sc1       = sc1_reg;
   assign bus.sc2       = sc2_reg;
   assign bus.game_over = go_reg;
   assign bus.winner    = win_reg;
endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter PADDLE_LEN, default 8, paddle height in rows (2..32).
REQ-002 SHALL have parameter WIN_SCORE, default 7, points needed to win (1..7).
REQ-003 SHALL have parameter PAUSE_TICKS, default 32, ticks held in POINT after a score (1..255).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-005 SHALL have these ports: tick input 1 frame-advance strobe; p1_up, p1_dn, p2_up, p2_dn input 1 each, paddle controls; serve input 1 start/restart request.
REQ-006 SHALL have these ports: bx, by output 6 ball column/row; p1y, p2y output 6 paddle top row; sc1, sc2 output 3 scores; game_over output 1; winner output 1 (0 = P1, 1 = P2). All are registered and feed the LED matrix renderer directly.

Function
REQ-007 SHALL implement states IDLE, PLAY, POINT, OVER.
REQ-008 SHALL change positions only on cycles with tick=1; serve SHALL be sampled every cycle.
REQ-009 Paddles, all states except OVER, on tick: up and not dn decrements the top row, saturating at 0. Dn and not up increments it, saturating at 64-PADDLE_LEN. Both or neither leaves it unchanged.
REQ-010 IDLE: ball held at (32,32). Serve=1 moves to PLAY next cycle; serve direction is the dx/dy latched at the last point (reset: dx right, dy down).
REQ-011 PLAY, each tick, ball steps +/-1 in x and y together.
REQ-012 Wall bounce: by=0 with dy up sets dy down and by=1. By=63 with dy down sets dy up and by=62.
REQ-013 P1 paddle sits at column 1: bx=2, dx left, by in [p1y, p1y+PADDLE_LEN-1] sets dx right and bx=3.
REQ-014 P2 paddle sits at column 62: bx=61, dx right, by inside the p2 span sets dx left and bx=60.
REQ-015 Wall and paddle bounces on the same tick SHALL both apply (corner reflection).
REQ-016 Miss: bx=0 with dx left gives sc2+1; bx=63 with dx right gives sc1+1. Either moves to POINT with the pause counter loaded to PAUSE_TICKS, and the ball frozen at the miss position.
REQ-017 Paddle span checks SHALL use the paddle positions registered before the current tick's paddle update.
REQ-018 POINT: the pause counter decrements per tick. At 0 the ball re-centres to (32,32), dx points toward the player who conceded, dy toggles, and the state moves to IDLE.
REQ-019 If the new score equals WIN_SCORE, SHALL go to OVER instead of POINT, with game_over=1 and winner = the scorer.
REQ-020 OVER: all positions frozen, scores held. Serve=1 clears scores, game_over and winner, re-centres ball and paddles, and goes to IDLE.
REQ-021 Scores SHALL never exceed WIN_SCORE; 3-bit arithmetic, no wrap.

Reset
REQ-022 On rst=1 at a clk edge, rst SHALL override tick/serve. Results: state IDLE; bx=by=32; p1y=p2y=(64-PADDLE_LEN)/2; sc1=sc2=0; game_over=0; winner=0; dx right; dy down; pause counter 0.
REQ-023 Reset mid-rally or mid-pause SHALL take effect in one cycle with no residual state.

Configuration
REQ-024 With macro PONG_AI_EN defined, P2 SHALL be computer-controlled. On tick it steps 1 row toward aligning p2y+PADDLE_LEN/2 with by; p2_up and p2_dn are ignored. REQ-009 limits still apply.
REQ-025 Without PONG_AI_EN, p2 SHALL follow p2_up and p2_dn per REQ-009.

Verification
REQ-026 Reset then hold p1_up for 40 ticks -> p1y=0, p2y=28, ball (32,32), state IDLE.
REQ-027 Serve, run 31 ticks with no paddle input -> bx=63, by=63. Next tick -> sc1=1, POINT; after PAUSE_TICKS ticks -> ball (32,32), IDLE.
REQ-028 Force the ball to approach the P1 paddle at by=p1y+3 with dx left -> at bx=2 it reflects to bx=3, dx right, no score change.
REQ-029 Ball at by=0, bx=61, moving up-right, p2y=0 -> next tick by=1, bx=60, dx left, dy down.
REQ-030 P2 scores 7 times -> sc2=7, game_over=1, winner=1, inputs ignored. Serve -> scores 0, IDLE. Assert rst mid-PLAY -> all REQ-022 values on next cycle.
REQ-031 With PONG_AI_EN, 64 ticks of PLAY with p2 inputs toggling -> the P2 paddle never misses at default parameters.
